op_mem: RTL and testbench

OP_MEM -- requirements
Module: op_mem

---
 rtl/op_mem.sv | 153 +++++++++++++++
 tb/tb_op_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/op_mem.sv
// rtl/op_mem.sv - memory-mapped LED, seven-segment and LCD output registers
// Optional LCD enable strobe sequencer: define OP_MEM_LCD_EN.
module op_mem #(
  parameter int LCD_SETUP_CYC = 2,
  parameter int LCD_PULSE_CYC = 12,
  parameter int LCD_HOLD_CYC  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_wren,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_op_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam logic [31:0] HEX_MASK = 32'h7F7F_7F7F;
  localparam logic [31:0] LCD_MASK = 32'h8000_03FF;
  localparam logic [2:0]  PARAM_OK = {LCD_SETUP_CYC >= 1, LCD_PULSE_CYC >= 1, LCD_HOLD_CYC >= 1};

  logic        hit;
  logic [3:0]  idx;
  logic [31:0] wmask;
  logic [31:0] ledr_q, ledg_q, hex_lo_q, hex_hi_q, lcd_q;
  logic        busy;
  logic        lcd_wr;
  logic        unused;

  assign hit    = (i_lsu_addr[31:8] == 24'h000070);
  assign idx    = i_lsu_addr[5:2];
  assign wmask  = {{8{i_bmask[3]}}, {8{i_bmask[2]}}, {8{i_bmask[1]}}, {8{i_bmask[0]}}};
  // LCD writes are dropped whole while a strobe is in flight
  assign lcd_wr = i_lsu_wren && hit && (idx == 4'd12) && !busy;
  assign unused = &{1'b0, PARAM_OK, i_lsu_addr[7:6], i_lsu_addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] fmask);
    return ((old & ~wmask) | (i_st_data & wmask)) & fmask;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hex_lo_q <= '0;
      hex_hi_q <= '0;
      lcd_q    <= '0;
    end else if (i_lsu_wren && hit) begin
      case (idx)
        4'd0:    ledr_q   <= merge(ledr_q, 32'hFFFF_FFFF);
        4'd4:    ledg_q   <= merge(ledg_q, 32'hFFFF_FFFF);
        4'd8:    hex_lo_q <= merge(hex_lo_q, HEX_MASK);
        4'd9:    hex_hi_q <= merge(hex_hi_q, HEX_MASK);
        4'd12:   if (lcd_wr) lcd_q <= merge(lcd_q, LCD_MASK);
        default: ;
      endcase
    end
  end

`ifdef OP_MEM_LCD_EN
  localparam int CNT_MAX = (LCD_SETUP_CYC > LCD_PULSE_CYC) ?
                           ((LCD_SETUP_CYC > LCD_HOLD_CYC) ? LCD_SETUP_CYC : LCD_HOLD_CYC) :
                           ((LCD_PULSE_CYC > LCD_HOLD_CYC) ? LCD_PULSE_CYC : LCD_HOLD_CYC);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          en_q;

  // counter holds remaining cycles minus one; each state exits when it reaches zero
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      en_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (lcd_wr && i_bmask[0]) begin
          state <= SETUP;
          cnt   <= CW'(LCD_SETUP_CYC - 1);
        end
        SETUP: if (cnt == '0) begin
          state <= PULSE;
          cnt   <= CW'(LCD_PULSE_CYC - 1);
          en_q  <= 1'b1;
        end else cnt <= cnt - 1'b1;
        PULSE: if (cnt == '0) begin
          state <= HOLD;
          cnt   <= CW'(LCD_HOLD_CYC - 1);
          en_q  <= 1'b0;
        end else cnt <= cnt - 1'b1;
        HOLD: if (cnt == '0) state <= IDLE;
              else cnt <= cnt - 1'b1;
        default: begin
          state <= IDLE;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign o_lcd_en = en_q;
`else
  assign busy     = 1'b0;
  assign o_lcd_en = 1'b0;
`endif

  always_comb begin
    o_op_data = '0;
    if (hit) begin
      case (idx)
        4'd0:    o_op_data = ledr_q;
        4'd4:    o_op_data = ledg_q;
        4'd8:    o_op_data = hex_lo_q;
        4'd9:    o_op_data = hex_hi_q;
        4'd12:   o_op_data = lcd_q | {1'b0, busy, 30'b0};
        default: o_op_data = '0;
      endcase
    end
  end

  assign o_io_ledr  = ledr_q;
  assign o_io_ledg  = ledg_q;
  assign o_io_hex0  = ~hex_lo_q[6:0];
  assign o_io_hex1  = ~hex_lo_q[14:8];
  assign o_io_hex2  = ~hex_lo_q[22:16];
  assign o_io_hex3  = ~hex_lo_q[30:24];
  assign o_io_hex4  = ~hex_hi_q[6:0];
  assign o_io_hex5  = ~hex_hi_q[14:8];
  assign o_io_hex6  = ~hex_hi_q[22:16];
  assign o_io_hex7  = ~hex_hi_q[30:24];
  assign o_lcd_data = lcd_q[7:0];
  assign o_lcd_rs   = lcd_q[8];
  assign o_lcd_rw   = lcd_q[9];
  assign o_lcd_on   = lcd_q[31];

endmodule

// File: tb/tb_op_mem.sv
// tb/tb_op_mem.sv - self-checking bench for op_mem (register map, readback, LCD strobe, reset)
module tb_op_mem;

`ifdef OP_MEM_LCD_EN
  localparam bit LCD = 1'b1;
`else
  localparam bit LCD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_lsu_wren = 1'b0;
  logic [31:0] i_lsu_addr = 32'h0000_7030;
  logic [31:0] i_st_data = '0;
  logic [3:0]  i_bmask = '0;
  logic [31:0] o_op_data, o_io_ledr, o_io_ledg;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;

  op_mem dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_lsu_wren(i_lsu_wren), .i_lsu_addr(i_lsu_addr),
    .i_st_data(i_st_data), .i_bmask(i_bmask), .o_op_data(o_op_data),
    .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3),
    .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_ledr = '0, m_ledg = '0, m_hex_lo = '0, m_hex_hi = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] bm;
    bm = bytemask(m);
    if (a[31:8] == 24'h70) begin
      if (a[5:2] == 4'd0) m_ledr = (m_ledr & ~bm) | (d & bm);
      if (a[5:2] == 4'd4) m_ledg = (m_ledg & ~bm) | (d & bm);
      if (a[5:2] == 4'd8) m_hex_lo = ((m_hex_lo & ~bm) | (d & bm)) & 32'h7F7F_7F7F;
      if (a[5:2] == 4'd9) m_hex_hi = ((m_hex_hi & ~bm) | (d & bm)) & 32'h7F7F_7F7F;
    end
  endtask

  function automatic logic [55:0] hex_exp();
    logic [55:0] h;
    for (int n = 0; n < 4; n++) begin
      h[7*n +: 7]     = ~m_hex_lo[8*n +: 7];
      h[7*(n+4) +: 7] = ~m_hex_hi[8*n +: 7];
    end
    return h;
  endfunction

  function automatic logic [55:0] hex_act();
    return {o_io_hex7, o_io_hex6, o_io_hex5, o_io_hex4, o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0};
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    i_lsu_wren = 1'b1;
    i_lsu_addr = a;
    i_st_data  = d;
    i_bmask    = m;
    @(posedge i_clk);
    #1;
    i_lsu_wren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_first, en_cnt, en_rises, busy_cnt;
    logic en_prev;

    vecs[0] = '{32'h0000_7000, 32'hA5A5_A5A5, 4'b0011, 32'h0000_A5A5};
    vecs[1] = '{32'h0000_7020, 32'h7F06_3F5B, 4'b1111, 32'h7F06_3F5B};
    vecs[2] = '{32'h0000_7010, 32'h1234_5678, 4'b1010, 32'h1200_5600};
    vecs[3] = '{32'h0000_7024, 32'hFFFF_FFFF, 4'b0101, 32'h007F_007F};
    vecs[4] = '{32'h0000_7003, 32'hFFFF_0000, 4'b1100, 32'hFFFF_A5A5};
    vecs[5] = '{32'h0000_703C, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    vecs[6] = '{32'h0000_7100, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    vecs[7] = '{32'h0000_7000, 32'h0000_0000, 4'b0000, 32'hFFFF_A5A5};

    // reset state
    #23;
    check("rst_ledr", {32'h0, o_io_ledr}, 64'h0);
    check("rst_ledg", {32'h0, o_io_ledg}, 64'h0);
    check("rst_hex", {8'h0, hex_act()}, {8'h0, {8{7'h7F}}});
    check("rst_lcd", {52'h0, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on}, 64'h0);
    check("rst_rd_lcd", {32'h0, o_op_data}, 64'h0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;

    // register map table with scoreboard of expected readbacks
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_rd);
      model_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      store(vecs[i].addr, vecs[i].data, vecs[i].mask);
      check($sformatf("vec%0d_rd", i), {32'h0, o_op_data}, {32'h0, exp_q.pop_front()});
      check($sformatf("vec%0d_ledr", i), {32'h0, o_io_ledr}, {32'h0, m_ledr});
      check($sformatf("vec%0d_ledg", i), {32'h0, o_io_ledg}, {32'h0, m_ledg});
      check($sformatf("vec%0d_hex", i), {8'h0, hex_act()}, {8'h0, hex_exp()});
    end
    check("hex3_0_digits", {36'h0, o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0},
          {36'h0, 7'h00, 7'h79, 7'h40, 7'h24});
    check("lcd_untouched", {52'h0, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on}, 64'h0);

    // LCD strobe with a dropped LCD store and a live LEDG store during PULSE
    store(32'h0000_7030, 32'h8000_0141, 4'b1111);
    check("lcd_fields", {52'h0, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_on}, {52'h0, 8'h41, 1'b1, 1'b0, 1'b1});
    check("lcd_rd_busy", {32'h0, o_op_data}, {32'h0, 32'h8000_0141 | {1'b0, LCD, 30'b0}});
    busy_cnt = int'(o_op_data[30]);
    en_first = -1; en_cnt = 0; en_rises = 0; en_prev = o_lcd_en;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        i_lsu_wren = 1'b1; i_lsu_addr = 32'h0000_7030; i_st_data = 32'h0000_0042; i_bmask = 4'b0001;
      end else if (k == 8) begin
        i_lsu_wren = 1'b1; i_lsu_addr = 32'h0000_7010; i_st_data = 32'hCAFE_0000; i_bmask = 4'b1111;
      end
      @(posedge i_clk);
      #1;
      i_lsu_wren = 1'b0;
      i_lsu_addr = 32'h0000_7030;
      #1;
      if (o_lcd_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        if (!en_prev) en_rises++;
      end
      en_prev = o_lcd_en;
      if (o_op_data[30]) busy_cnt++;
    end
    check("en_first", 64'(en_first), LCD ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFF);
    check("en_cycles", 64'(en_cnt), LCD ? 64'd12 : 64'd0);
    check("en_pulses", 64'(en_rises), LCD ? 64'd1 : 64'd0);
    check("busy_cycles", 64'(busy_cnt), LCD ? 64'd16 : 64'd0);
    check("lcd_data_after_drop", {56'h0, o_lcd_data}, LCD ? 64'h41 : 64'h42);
    check("lcd_rs_kept", {63'h0, o_lcd_rs}, 64'h1);
    check("ledg_during_pulse", {32'h0, o_io_ledg}, 64'h0000_0000_CAFE_0000);
    check("lcd_rd_idle", {32'h0, o_op_data}, {32'h0, LCD ? 32'h8000_0141 : 32'h8000_0142});

    // asynchronous reset in the middle of PULSE
    store(32'h0000_7030, 32'h0000_0055, 4'b0001);
    repeat (5) @(posedge i_clk);
    #1;
    check("en_before_rst", {63'h0, o_lcd_en}, {63'h0, LCD});
    #1;
    i_rst = 1'b0;
    #1;
    check("rst_async_en", {63'h0, o_lcd_en}, 64'h0);
    check("rst_async_hex", {57'h0, o_io_hex0}, 64'h7F);
    check("rst_async_ledg", {32'h0, o_io_ledg}, 64'h0);
    check("rst_async_rd", {32'h0, o_op_data}, 64'h0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("idle_after_rst", {32'h0, o_op_data}, 64'h0);

    // a fresh strobe after release runs the full sequence
    store(32'h0000_7030, 32'h8000_0177, 4'b1111);
    en_first = -1; en_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk);
      #1;
      if (o_lcd_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
      end
    end
    check("post_rst_en_first", 64'(en_first), LCD ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFF);
    check("post_rst_en_cycles", 64'(en_cnt), LCD ? 64'd12 : 64'd0);
    check("post_rst_lcd_data", {56'h0, o_lcd_data}, 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
